// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin two-port arbiter and access sequencer for a
//            single-port data memory (strobe generation, load extension).
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [1:0]  size0,
    input  logic [1:0]  size1,
    input  logic        uns0,
    input  logic        uns1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        mem_WE,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic [3:0]  mem_writeStrobe,
    input  logic [31:0] mem_RD
);

    localparam logic [31:0] c_MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_ptr;      // index of the requester favoured on a tie
    logic        r_idx;
    logic        r_we;
    logic        r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic        w_any;
    logic        w_win;
    logic        w_err;
    logic [3:0]  w_strb;
    logic [31:0] w_shift;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign mem_A  = r_addr;
    assign mem_WD = r_wdata;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

    always_comb begin
        w_any = req0 | req1;
        w_win = (req0 & req1) ? r_ptr : req1;
        w_err = (r_size == 2'b11)
              || ((r_size == 2'b01) && r_addr[0])
              || ((r_size == 2'b10) && (r_addr[1:0] != 2'b00))
              || (r_addr >= c_MEM_LIMIT);
    end

    always_comb begin
        w_strb = 4'b0000;
        if (!r_we || w_err) begin
            w_strb = 4'b0000;
        end else begin
            case (r_size)
                2'b00:   w_strb = 4'b0001 << r_addr[1:0];
                2'b01:   w_strb = r_addr[1] ? 4'b1100 : 4'b0011;
                2'b10:   w_strb = 4'b1111;
                default: w_strb = 4'b0000;
            endcase
        end
    end

    // Load lane selection and extension; stores and errors return zero.
    always_comb begin
        w_shift = mem_RD >> {r_addr[1:0], 3'b000};
        w_half  = r_addr[1] ? mem_RD[31:16] : mem_RD[15:0];
        w_ext   = 32'd0;
        if (!r_we && !w_err) begin
            case (r_size)
                2'b00:   w_ext = r_uns ? {24'd0, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
                2'b01:   w_ext = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
                2'b10:   w_ext = mem_RD;
                default: w_ext = 32'd0;
            endcase
        end
    end

    always_comb begin
        w_next          = r_state;
        gnt0            = 1'b0;
        gnt1            = 1'b0;
        mem_WE          = 1'b0;
        mem_writeStrobe = 4'b0000;
        rvalid0         = 1'b0;
        rvalid1         = 1'b0;
        err0            = 1'b0;
        err1            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    gnt0   = ~w_win;
                    gnt1   = w_win;
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_WE          = r_we & ~w_err;
                mem_writeStrobe = w_strb;
                w_next          = S_RESP;
            end
            S_RESP: begin
                rvalid0 = ~r_idx;
                rvalid1 = r_idx;
                err0    = ~r_idx & w_err;
                err1    = r_idx & w_err;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= 1'b0;
            r_idx    <= 1'b0;
            r_we     <= 1'b0;
            r_uns    <= 1'b0;
            r_size   <= 2'b00;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdata0 <= 32'd0;
            r_rdata1 <= 32'd0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && w_any) begin
                r_idx   <= w_win;
                r_ptr   <= ~w_win;
                r_we    <= w_win ? we1    : we0;
                r_addr  <= w_win ? addr1  : addr0;
                r_wdata <= w_win ? wdata1 : wdata0;
                r_size  <= w_win ? size1  : size0;
                r_uns   <= w_win ? uns1   : uns0;
            end
            if (r_state == S_ACCESS) begin
                if (r_idx) begin
                    r_rdata1 <= w_ext;
                end else begin
                    r_rdata0 <= w_ext;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Randomized self-checking bench for dmem_arbiter against a
//            byte-array reference model.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, uns0, uns1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  size0, size1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_WE;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic [3:0]  mem_writeStrobe;

    logic        boot;
    logic [31:0] mem [64];
    logic [7:0]  ref_mem [256];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          last    = 1;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_BYTES(256)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .size0(size0), .size1(size1), .uns0(uns0), .uns1(uns1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD),
        .mem_writeStrobe(mem_writeStrobe), .mem_RD(mem_RD)
    );

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic int low_lane(logic [3:0] s);
        for (int j = 0; j < 4; j++) if (s[j]) return j;
        return 0;
    endfunction

    // Backing memory: unshifted write data is placed starting at the lowest strobed lane.
    assign mem_RD = mem[mem_A[7:2]];
    always @(posedge clk) begin
        if (boot) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (mem_WE) begin
            for (int j = 0; j < 4; j++)
                if (mem_writeStrobe[j])
                    mem[mem_A[7:2]][8*j +: 8] <= (mem_WD << (8 * low_lane(mem_writeStrobe))) >> (8 * j);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input bit r, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input bit u);
        if (p == 0) begin
            req0 = r; we0 = we; addr0 = a; wdata0 = wd; size0 = sz; uns0 = u;
        end else begin
            req1 = r; we1 = we; addr1 = a; wdata1 = wd; size1 = sz; uns1 = u;
        end
    endtask

    // Single access from one port; entered and left on a negedge with the DUT idle.
    task automatic do_acc(input int p, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input bit u);
        bit          e;
        int          nb;
        logic [3:0]  strb;
        logic [31:0] val, wdt;
        int          k;
        e  = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (a >= 256);
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        strb = 4'b0000;
        val  = 32'd0;
        if (!e) begin
            for (int i = 0; i < nb; i++) begin
                if (we) strb[a % 4 + i] = 1'b1;
                val = val | (32'(ref_mem[a + i]) << (8 * i));
            end
            if (!u && nb < 4 && val[8*nb-1]) val = val | (32'hFFFFFFFF << (8 * nb));
        end
        if (we || e) val = 32'd0;

        drive(p, 1'b1, we, a, wd, sz, u);
        #1;
        k = 0;
        while (!(p == 1 ? gnt1 : gnt0) && k < 4) begin
            @(negedge clk); #1; k++;
        end
        chk("gnt", {31'd0, (p == 1 ? gnt1 : gnt0)}, 32'd1);
        last = p;
        @(negedge clk);
        drive(p, 1'b0, 1'b0, $urandom, $urandom, 2'($urandom), 1'b0);
        chk("mem_WE", {31'd0, mem_WE}, {31'd0, we && !e});
        chk("strobe", {28'd0, mem_writeStrobe}, {28'd0, strb});
        chk("mem_A", mem_A, a);
        chk("mem_WD", mem_WD, wd);
        @(negedge clk);
        chk("rvalid", {30'd0, rvalid1, rvalid0}, (p == 1) ? 32'd2 : 32'd1);
        chk("err", {31'd0, (p == 1 ? err1 : err0)}, {31'd0, e});
        chk("rdata", (p == 1 ? rdata1 : rdata0), val);
        if (we && !e) begin
            wdt = wd;
            for (int i = 0; i < nb; i++) ref_mem[a + i] = wdt[8*i +: 8];
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] w, a, ref_w;
        int          ng, prev, p, sz;
        boot  = 1'b1;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            w = init_word(i);
            for (int j = 0; j < 4; j++) ref_mem[4*i + j] = w[8*j +: 8];
        end
        repeat (3) @(negedge clk);
        chk("rst_gnt",    {30'd0, gnt1, gnt0}, 32'd0);
        chk("rst_rvalid", {28'd0, err1, err0, rvalid1, rvalid0}, 32'd0);
        chk("rst_rdata",  rdata0 | rdata1, 32'd0);
        chk("rst_mem",    {27'd0, mem_WE, mem_writeStrobe}, 32'd0);
        chk("rst_A_WD",   mem_A | mem_WD, 32'd0);
        boot  = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Directed accesses
        do_acc(0, 1, 32'h10, 32'hDEADBEEF, 2'd2, 0);
        do_acc(0, 0, 32'h10, 32'h0, 2'd2, 0);
        chk("word_ld", rdata0, 32'hDEADBEEF);
        do_acc(0, 1, 32'h13, 32'h000000AB, 2'd0, 0);
        do_acc(0, 0, 32'h13, 32'h0, 2'd0, 0);
        chk("sbyte_ld", rdata0, 32'hFFFFFFAB);
        do_acc(1, 0, 32'h13, 32'h0, 2'd0, 1);
        chk("ubyte_ld", rdata1, 32'h000000AB);
        do_acc(1, 1, 32'h22, 32'h00008001, 2'd1, 0);
        do_acc(0, 0, 32'h22, 32'h0, 2'd1, 0);
        chk("shalf_ld", rdata0, 32'hFFFF8001);
        do_acc(1, 0, 32'h22, 32'h0, 2'd1, 1);
        chk("uhalf_ld", rdata1, 32'h00008001);
        do_acc(0, 1, 32'h11, 32'h1234, 2'd1, 0);
        do_acc(1, 0, 32'h100, 32'h0, 2'd2, 0);
        do_acc(0, 0, 32'h4, 32'h0, 2'd3, 0);

        // Both requesters held: winners alternate, grants 3 cycles apart
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
        drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0);
        ng = 0;
        prev = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (gnt0 || gnt1) begin
                chk("rr_one", {31'd0, gnt0 & gnt1}, 32'd0);
                chk("rr_who", {31'd0, gnt1}, 32'(1 - last));
                if (ng > 0) chk("rr_gap", 32'(cyc - prev), 32'd3);
                last = gnt1 ? 1 : 0;
                prev = cyc;
                ng++;
                if (ng == 4) break;
            end
            @(negedge clk);
        end
        chk("rr_count", 32'(ng), 32'd4);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        repeat (3) @(negedge clk);

        // Reset during ACCESS drops the write and the response
        drive(0, 1'b1, 1'b1, 32'h40, 32'h12345678, 2'd2, 1'b0);
        #1;
        chk("rst_acc_gnt", {31'd0, gnt0}, 32'd1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        chk("rst_acc_we", {31'd0, mem_WE}, 32'd1);
        #1 reset = 1'b1;
        #1 chk("rst_async_we", {31'd0, mem_WE}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("rst_no_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
            @(negedge clk);
        end
        ref_w = {ref_mem[16'h43], ref_mem[16'h42], ref_mem[16'h41], ref_mem[16'h40]};
        chk("rst_mem_kept", mem[16], ref_w);
        drive(0, 1'b1, 1'b0, 32'h30, 32'h0, 2'd2, 1'b0);
        drive(1, 1'b1, 1'b0, 32'h34, 32'h0, 2'd2, 1'b0);
        #1;
        chk("rst_first_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        repeat (3) @(negedge clk);
        last = 0;

        // Randomized accesses
        for (int t = 0; t < 60; t++) begin
            p  = $urandom_range(0, 1);
            sz = $urandom_range(0, 3);
            a  = $urandom_range(0, 287);
            if ($urandom_range(0, 2) != 0 && sz != 3) a = a & ~((32'd1 << sz) - 1);
            do_acc(p, 1'($urandom), a, $urandom, 2'(sz), 1'($urandom));
        end

        for (int i = 0; i < 64; i++) begin
            ref_w = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
            chk("final_mem", mem[i], ref_w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
